// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Checker and decoder for a right-rotating one-hot ring counter phase bus.
//   Each enabled cycle the ring output is sampled, the hot bit is converted
//   to a binary index, completed revolutions are counted, and illegal,
//   stalled or skipped phases are flagged. A three-state FSM tracks whether
//   the ring is trusted.
//
// Ports:
//   c          clock, all state updates on posedge
//   r          asynchronous active-low reset
//   en         sample qualifier, q ignored when low
//   clr        synchronous clear of rev, err, err_cnt (FSM unaffected)
//   q          ring phase from upstream ring counter
//   idx        binary index of the hot bit of the last accepted sample
//   idx_valid  high while in LOCK
//   rev        completed revolutions, modulo 2^REV_W
//   wrap       one-cycle pulse per completed revolution
//   err        sticky fault flag
//   err_cnt    fault episodes, saturating
//   state      FSM state: IDLE=00, LOCK=01, FAULT=10 (11 behaves as FAULT)
module ring_phase_monitor #(
    parameter int N     = 4,
    parameter int REV_W = 8,
    parameter int ERR_W = 4,
    localparam int IW   = $clog2(N)
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     q,
    output logic [IW-1:0]    idx,
    output logic             idx_valid,
    output logic [REV_W-1:0] rev,
    output logic             wrap,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK  = 2'b01,
        FAULT = 2'b10
    } state_t;

    // Pattern the upstream ring presents straight out of its own reset.
    localparam logic [N-1:0] RESYNC = {1'b1, {(N-1){1'b0}}};

    state_t         st;
    logic [N-1:0]   p;
    logic [N-1:0]   p_next;
    logic           legal;

    function automatic logic [IW-1:0] hot_index(input logic [N-1:0] v);
        logic [IW-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) res = IW'(i);
        end
        return res;
    endfunction

    assign p_next = {p[0], p[N-1:1]};
    assign legal  = $onehot(q);
    assign state  = st;

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            st        <= IDLE;
            p         <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            rev       <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            wrap <= 1'b0;

            if (clr) begin
                rev     <= '0;
                err     <= 1'b0;
                err_cnt <= '0;
            end

            // Later assignments below override the clear: a fault entry
            // in the same cycle still records err=1 / err_cnt=1, while a
            // wrap leaves rev cleared but still pulses.
            if (en) begin
                case (st)
                    IDLE: begin
                        if (legal) begin
                            st        <= LOCK;
                            p         <= q;
                            idx       <= hot_index(q);
                            idx_valid <= 1'b1;
                        end
                    end
                    LOCK: begin
                        if (q == p_next) begin
                            p   <= q;
                            idx <= hot_index(q);
                            if (p[0]) begin
                                wrap <= 1'b1;
                                if (!clr) rev <= rev + 1'b1;
                            end
                        end else begin
                            st        <= FAULT;
                            idx_valid <= 1'b0;
                            err       <= 1'b1;
                            if (clr)
                                err_cnt <= ERR_W'(1);
                            else if (err_cnt != '1)
                                err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (q == RESYNC) begin
                            st        <= LOCK;
                            p         <= q;
                            idx       <= IW'(N - 1);
                            idx_valid <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
module tb_ring_phase_monitor;

    localparam int N     = 4;
    localparam int REV_W = 3;
    localparam int ERR_W = 4;
    localparam int IW    = 2;

    logic             c = 1'b0;
    logic             r = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic [N-1:0]     q = '0;
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic [REV_W-1:0] rev;
    logic             wrap;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    ring_phase_monitor #(.N(N), .REV_W(REV_W), .ERR_W(ERR_W)) dut (
        .c(c), .r(r), .en(en), .clr(clr), .q(q),
        .idx(idx), .idx_valid(idx_valid), .rev(rev), .wrap(wrap),
        .err(err), .err_cnt(err_cnt), .state(state)
    );

    always #5 c = ~c;

    int checks = 0;
    int passed = 0;

    // Reference model: phase tracked as an integer position of the hot bit.
    int m_state;   // 0 idle, 1 locked, 2 faulted
    int m_pos;
    int m_idx;
    int m_rev;
    int m_wrap;
    int m_err;
    int m_cnt;

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_idx = 0; m_rev = 0;
        m_wrap = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic e, input logic cl, input logic [N-1:0] qq);
        int ones;
        int pos;
        bit fault;
        ones = $countones(qq);
        pos = 0;
        for (int i = 0; i < N; i++) if (qq[i]) pos = i;
        m_wrap = 0;
        fault = 0;
        if (e) begin
            case (m_state)
                0: if (ones == 1) begin m_state = 1; m_pos = pos; m_idx = pos; end
                1: begin
                    if (ones == 1 && pos == (m_pos + N - 1) % N) begin
                        if (m_pos == 0) begin
                            m_wrap = 1;
                            m_rev = (m_rev + 1) % (1 << REV_W);
                        end
                        m_pos = pos;
                        m_idx = pos;
                    end else begin
                        m_state = 2;
                        fault = 1;
                    end
                end
                default: if (int'(qq) == (1 << (N - 1))) begin
                    m_state = 1; m_pos = N - 1; m_idx = N - 1;
                end
            endcase
        end
        if (cl) begin m_rev = 0; m_err = 0; m_cnt = 0; end
        if (fault) begin
            m_err = 1;
            m_cnt = (m_cnt < (1 << ERR_W) - 1) ? m_cnt + 1 : (1 << ERR_W) - 1;
        end
    endtask

    function automatic logic [13:0] pk(int i, int v, int rv, int w, int e, int cn, int s);
        logic [13:0] res;
        res = {i[1:0], v[0], rv[2:0], w[0], e[0], cn[3:0], s[1:0]};
        return res;
    endfunction

    function automatic logic [13:0] model_vec();
        return pk(m_idx, (m_state == 1) ? 1 : 0, m_rev, m_wrap, m_err, m_cnt, m_state);
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {idx, idx_valid, rev, wrap, err, err_cnt, state};
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0t: got idx=%0d v=%0d rev=%0d wrap=%0d err=%0d cnt=%0d st=%0d, need idx=%0d v=%0d rev=%0d wrap=%0d err=%0d cnt=%0d st=%0d",
                      name, $time, act[13:12], act[11], act[10:8], act[7], act[6], act[5:2], act[1:0],
                      exp[13:12], exp[11], exp[10:8], exp[7], exp[6], exp[5:2], exp[1:0]);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s @%0t: got %0d, need %0d", name, $time, act, exp);
    endtask

    // Drive inputs, clock once, advance the model, settle just past the edge.
    task automatic step(input logic e, input logic cl, input logic [N-1:0] qq);
        en = e; clr = cl; q = qq;
        @(posedge c);
        model_step(e, cl, qq);
        #1;
    endtask

    typedef struct {
        logic       e;
        logic       cl;
        logic [3:0] qq;
        int         i, v, rv, w, er, cn, s;
    } vec_t;

    vec_t tbl[25];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wraps;
        int rp;
        logic e;
        logic cl;
        logic [N-1:0] qq;

        //            en  clr  q        idx v rev w err cnt st
        tbl[0]  = '{1'b0, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 4'b0110, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 4'b1000, 3, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{1'b1, 1'b0, 4'b0100, 2, 1, 0, 0, 0, 0, 1};
        tbl[4]  = '{1'b1, 1'b0, 4'b0010, 1, 1, 0, 0, 0, 0, 1};
        tbl[5]  = '{1'b1, 1'b0, 4'b0001, 0, 1, 0, 0, 0, 0, 1};
        tbl[6]  = '{1'b1, 1'b0, 4'b1000, 3, 1, 1, 1, 0, 0, 1};
        tbl[7]  = '{1'b0, 1'b0, 4'b1111, 3, 1, 1, 0, 0, 0, 1};
        tbl[8]  = '{1'b1, 1'b0, 4'b0100, 2, 1, 1, 0, 0, 0, 1};
        tbl[9]  = '{1'b1, 1'b0, 4'b0110, 2, 0, 1, 0, 1, 1, 2};
        tbl[10] = '{1'b1, 1'b0, 4'b0010, 2, 0, 1, 0, 1, 1, 2};
        tbl[11] = '{1'b1, 1'b0, 4'b0001, 2, 0, 1, 0, 1, 1, 2};
        tbl[12] = '{1'b1, 1'b0, 4'b1000, 3, 1, 1, 0, 1, 1, 1};
        tbl[13] = '{1'b1, 1'b0, 4'b0100, 2, 1, 1, 0, 1, 1, 1};
        tbl[14] = '{1'b1, 1'b0, 4'b0100, 2, 0, 1, 0, 1, 2, 2};
        tbl[15] = '{1'b1, 1'b0, 4'b1000, 3, 1, 1, 0, 1, 2, 1};
        tbl[16] = '{1'b1, 1'b1, 4'b0100, 2, 1, 0, 0, 0, 0, 1};
        tbl[17] = '{1'b1, 1'b1, 4'b0100, 2, 0, 0, 0, 1, 1, 2};
        tbl[18] = '{1'b1, 1'b0, 4'b1000, 3, 1, 0, 0, 1, 1, 1};
        tbl[19] = '{1'b1, 1'b0, 4'b0001, 3, 0, 0, 0, 1, 2, 2};
        tbl[20] = '{1'b1, 1'b0, 4'b1000, 3, 1, 0, 0, 1, 2, 1};
        tbl[21] = '{1'b1, 1'b0, 4'b0100, 2, 1, 0, 0, 1, 2, 1};
        tbl[22] = '{1'b1, 1'b0, 4'b0010, 1, 1, 0, 0, 1, 2, 1};
        tbl[23] = '{1'b1, 1'b0, 4'b0001, 0, 1, 0, 0, 1, 2, 1};
        tbl[24] = '{1'b1, 1'b1, 4'b1000, 3, 1, 0, 1, 0, 0, 1};

        // Reset state
        model_reset();
        r = 1'b0;
        repeat (2) @(posedge c);
        #1;
        check("reset_state", pk(0, 0, 0, 0, 0, 0, 0));
        @(negedge c);
        r = 1'b1;
        @(negedge c);

        // Table vectors
        for (int k = 0; k < 25; k++) begin
            step(tbl[k].e, tbl[k].cl, tbl[k].qq);
            check($sformatf("vec%0d", k),
                  pk(tbl[k].i, tbl[k].v, tbl[k].rv, tbl[k].w, tbl[k].er, tbl[k].cn, tbl[k].s));
        end

        // 12 clean revolutions with a 3-bit revolution counter
        wraps = 0;
        for (int k = 1; k <= 12; k++) begin
            for (int ph = 2; ph >= -1; ph--) begin
                rp = (ph < 0) ? 3 : ph;
                step(1'b1, 1'b0, 4'(1 << rp));
                if (wrap) wraps++;
                check("rev_run", model_vec());
            end
            check_val("rev_count", int'(rev), k % 8);
        end
        check_val("wrap_total", wraps, 12);

        // Repeated stall fault episodes: counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 4'b1000);
            check_val("err_cnt_sat", int'(err_cnt), (k < 15) ? k : 15);
            step(1'b1, 1'b0, 4'b1000);
            check("resync", model_vec());
        end

        // Asynchronous reset mid-revolution, between edges
        step(1'b1, 1'b0, 4'b0100);
        step(1'b1, 1'b0, 4'b0010);
        check("pre_rst", model_vec());
        #2;
        r = 1'b0;
        model_reset();
        #1;
        check("async_rst", pk(0, 0, 0, 0, 0, 0, 0));
        en = 1'b1; q = 4'b0001;
        @(posedge c);
        #1;
        check("rst_hold", pk(0, 0, 0, 0, 0, 0, 0));
        en = 1'b0;
        @(negedge c);
        r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 4'b1000);
            check("idle_en0", pk(0, 0, 0, 0, 0, 0, 0));
        end
        step(1'b1, 1'b0, 4'b0010);
        check("relock", pk(1, 1, 0, 0, 0, 0, 1));

        // Randomised run against the reference model
        for (int k = 0; k < 400; k++) begin
            rp = $urandom_range(0, 99);
            e  = ($urandom_range(0, 99) < 85);
            cl = ($urandom_range(0, 99) < 4);
            if (m_state == 2 && rp < 35)
                qq = 4'b1000;
            else if (rp < 8)
                qq = 4'($urandom_range(0, 15));
            else if (rp < 12)
                qq = 4'(1 << m_pos);
            else
                qq = 4'(1 << ((m_pos + N - 1) % N));
            step(e, cl, qq);
            check("random", model_vec());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Downstream checker and decoder for the 4-bit right-rotating one-hot ring counter phase bus. It samples the ring output every enabled cycle and converts the hot bit to a binary index. It counts completed revolutions and detects illegal, stalled or skipped phases. A three-state lock FSM tracks whether the ring is trusted, and status outputs go to the control/debug register bank.

## Interface
- N, default 4: ring width; legal range N >= 2.
- REV_W, default 8: revolution counter width.
- ERR_W, default 4: fault counter width.

Ports (IW = $clog2(N)):
- c  in  1  clock; all state updates on posedge.
- r  in  1  reset; one clock, reset asynchronous and active-low (r=0 resets immediately, release synchronised by user).
- en  in  1  sample qualifier; tie to "upstream ring out of reset". q is ignored when en=0.
- clr  in  1  synchronous clear of rev, err, err_cnt; FSM unaffected.
- q  in  N  ring phase from the upstream ring counter.
- idx  out  IW  binary index of the hot bit of the last accepted sample.
- idx_valid  out  1  high while in LOCK.
- rev  out  REV_W  completed revolutions, modulo 2^REV_W.
- wrap  out  1  one-cycle pulse per completed revolution.
- err  out  1  sticky fault flag.
- err_cnt  out  ERR_W  fault episodes, saturating at all-ones.
- state  out  2  FSM state: IDLE=00, LOCK=01, FAULT=10 (11 is unreachable and decodes as FAULT).

## Operation
- Legal sample: q has exactly one bit set.
- Expected next phase: ror(p) = {p[0], p[N-1:1]}, where p is the last accepted phase. The sequence for N=4 is 1000→0100→0010→0001→1000.
- IDLE: on en and a legal sample, go to LOCK, set p=q and idx=index(q). Illegal samples are ignored and not counted.
- LOCK, en=1:
  - q == ror(p): stay in LOCK and set p=q, idx=index(q). If p[0]==1 (wrap 0001→1000 for N=4), pulse wrap and increment rev.
  - Any other q (illegal, stalled or skipped): go to FAULT, set err=1, increment err_cnt (saturating). p and idx hold.
- FAULT:
  - On en and q == {1, 0…0} (upstream reset pattern): resync to LOCK with p=q, idx=N-1, and no wrap.
  - All other samples hold in FAULT with no further count, so a fault episode counts exactly once.
- en=0: all state holds and wrap is 0.
- clr zeroes rev, err and err_cnt. If clr and a fault entry occur in the same cycle, the fault wins: err=1, err_cnt=1. If clr and a wrap occur in the same cycle, rev=0 and wrap still pulses.
- rev wraps from 2^REV_W-1 to 0 silently.

## Timing
- All outputs are registered. A sample accepted on edge k is reflected in idx, idx_valid, state, rev and err after edge k, giving 1-cycle latency from q to outputs.
- wrap is high for exactly the one cycle following the accepting edge.
- Reset (r=0, asynchronous, any time including mid-revolution or in FAULT) forces: idx=0, idx_valid=0, rev=0, wrap=0, err=0, err_cnt=0, state=IDLE, p=0. No output glitches to non-reset values while r=0.
- After r rises, the first legal en sample locks on the next edge.
- A stall of one enabled cycle (q unchanged) is a fault. A bench holding the upstream ring in reset must hold en=0.

## Test plan
- Reset, then en=1 with q cycling 1000,0100,0010,0001,1000 → lock after first edge with idx 3,2,1,0,3; one wrap pulse on the 0001→1000 sample; rev=1; err=0.
- Drive 12 clean revolutions with REV_W=3 → rev counts 1…7,0,1…4; 12 wrap pulses.
- In LOCK, inject 0110, then 0010, 0001 → FAULT entered, err=1, err_cnt=1, idx_valid=0; further samples do not increment. Then q=1000 → LOCK with idx=3.
- Stall: in LOCK, q=0100 twice → FAULT. Repeat 20 fault episodes with ERR_W=4 → err_cnt saturates at 15.
- clr asserted on the same edge as a fault → err=1, err_cnt=1, rev=0. clr alone in LOCK → err=0, err_cnt=0, state stays LOCK.
- Assert r=0 between clock edges mid-revolution → all outputs are at reset values immediately. On release, en=0 for 3 cycles → state stays IDLE.
